sync3_cnt_monitor: RTL and testbench
====================================

// Module: sync3_cnt_monitor
// PURPOSE
//  Downstream monitor for the 3-bit synchronous ripple-free counter (CH2_SYNC_3CNT family).
//  Samples counter output CNT_IN each rising CLK edge, after the counter's falling-edge update.
//  Checks the +1 mod 2^CNT_W sequence, emits match/wrap pulses, counts wraps and flags sequence faults.
//  Feeds status/LED logic and the board-level test harness.
// PARAMETERS
//  CNT_W      3  width of monitored counter value
//  WRAP_W     8  width of saturating wrap counter WRAP_COUNT
//  ERR_LIMIT  3  consecutive mismatches that force FAULT state (1..15)
// PORTS
//  CLK          in   1       system clock; all state updates on rising edge
//  RST          in   1       synchronous, active-high reset
//  EN           in   1       monitor enable; 0 forces IDLE
//  CNT_IN       in   CNT_W   counter value under test
//  MATCH_VAL    in   CNT_W   compare value for MATCH_PULSE
//  CLR_ERR      in   1       clear SEQ_ERR/consecutive-error count; exits FAULT
//  MATCH_PULSE  out  1       1-cycle pulse: CNT_IN==MATCH_VAL sampled in TRACK
//  WRAP_PULSE   out  1       1-cycle pulse: all-ones -> 0 transition sampled in TRACK
//  WRAP_COUNT   out  WRAP_W  number of wraps, saturating at all-ones
//  SEQ_ERR      out  1       sticky: any mismatch since last clear
//  LOCKED       out  1       1 while the last TRACK sample was legal
//  STATE        out  2       FSM state: 0 IDLE, 1 ACQUIRE, 2 TRACK, 3 FAULT
// BEHAVIOUR
//  Reset (RST=1 at rising edge): STATE=IDLE, prev=0, err_cnt=0, all outputs 0, WRAP_COUNT=0.
//  Priority at each edge: RST > EN==0 (-> IDLE) > CLR_ERR > normal transition.
//  IDLE: outputs hold except pulses=0, LOCKED=0; EN=1 -> ACQUIRE.
//  ACQUIRE: prev<=CNT_IN, no check, no pulses; -> TRACK next edge.
//  TRACK: exp = prev+1 (mod 2^CNT_W, natural wrap); prev<=CNT_IN always.
//   CNT_IN==exp: err_cnt<=0, LOCKED<=1.
//   CNT_IN!=exp (including hold): SEQ_ERR<=1, LOCKED<=0, err_cnt++;
//    err_cnt reaching ERR_LIMIT -> FAULT.
//   WRAP: prev==all-ones && CNT_IN==0 -> WRAP_PULSE=1, WRAP_COUNT++ (saturate, no rollover).
//   MATCH: CNT_IN==MATCH_VAL -> MATCH_PULSE=1; evaluated regardless of legality.
//   Wrap and match in same sample: both pulse.
//  FAULT: pulses=0, LOCKED=0, prev tracks CNT_IN; only CLR_ERR (-> ACQUIRE) or EN=0 exits.
//  CLR_ERR in TRACK: SEQ_ERR<=0, err_cnt<=0, stay TRACK; a mismatch in the same cycle wins (SEQ_ERR=1).
//  Latency: all outputs registered; response visible 1 CLK after the sampling edge.
//  WRAP_COUNT cleared only by RST; held through IDLE/FAULT.
//  EN deassert mid-TRACK: next edge IDLE; SEQ_ERR and WRAP_COUNT retained.
// CONFIGURATION
//  SYNC3_MON_ERR_CAPTURE_EN defined: adds outputs ERR_EXP[CNT_W] and ERR_GOT[CNT_W];
//   capture exp/CNT_IN of the first mismatch while SEQ_ERR==0; frozen until CLR_ERR or RST (-> 0).
//  Undefined: ports and capture registers absent; all other behaviour identical.
// STRUCTURE
//  Package sync3_mon_pkg: state encoding localparams (ST_IDLE..ST_FAULT), STATE width 2.
//  Sub-module sync3_mon_sat_cnt (param W): enable-increment saturating counter with sync clear,
//   used for WRAP_COUNT and err_cnt.
//  Top: FSM, prev register, exp/compare logic, pulse registers.
// TESTING
//  Reset, EN=1, CNT_IN 0,1,..7,0 -> STATE IDLE->ACQUIRE->TRACK; LOCKED=1; one WRAP_PULSE; WRAP_COUNT=1.
//  MATCH_VAL=5, legal sequence for 16 cycles -> MATCH_PULSE exactly 2 times, each 1 cycle wide.
//  In TRACK, inject 3->6 once -> SEQ_ERR=1, LOCKED=0 1 cycle; resync 6->7 -> LOCKED=1, STATE stays TRACK.
//  Hold CNT_IN=2 for 4 samples -> FAULT after 3rd mismatch; CLR_ERR -> ACQUIRE, SEQ_ERR=0.
//  WRAP_W=2, 5 wraps -> WRAP_COUNT saturates at 3; RST mid-TRACK -> all outputs 0 next cycle.
//  With SYNC3_MON_ERR_CAPTURE_EN: sequence 1,2,4,0 -> ERR_EXP=3, ERR_GOT=4 (second error not captured).

Source files
------------

// File: rtl/sync3_mon_pkg.sv
// Shared definitions for the 3-bit counter sequence monitor: FSM state
// encoding and widths that the top level and its ports depend on.
package sync3_mon_pkg;

  localparam int STATE_W = 2;
  // Holds the consecutive-mismatch count; ERR_LIMIT is at most 15.
  localparam int ERR_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_FAULT   = 2'd3
  } mon_state_e;

endpackage

// File: rtl/sync3_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear. Used for the wrap count and
// for the consecutive-mismatch count. When clear and increment arrive in the
// same cycle the result is 1, so the event that coincides with a clear is
// still counted.
module sync3_mon_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over hold, increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sync3_cnt_monitor.sv
// Sequence monitor for the 3-bit synchronous counter. Samples CNT_IN on each
// rising CLK edge, checks the +1 (mod 2^CNT_W) progression, and reports
// match/wrap pulses, a saturating wrap count and a sticky sequence error.
// Optional feature macro: SYNC3_MON_ERR_CAPTURE_EN adds ERR_EXP/ERR_GOT,
// which hold the expected and observed values of the first mismatch.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | monitor disabled; pulses and LOCKED low, status held
// ST_ACQUIRE | take first sample as reference, no checking
// ST_TRACK   | check each sample against prev+1, raise pulses
// ST_FAULT   | ERR_LIMIT consecutive mismatches; wait for CLR_ERR or EN=0
module sync3_cnt_monitor
  import sync3_mon_pkg::*;
#(
  parameter int CNT_W     = 3,
  parameter int WRAP_W    = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [CNT_W-1:0]   CNT_IN,
  input  logic [CNT_W-1:0]   MATCH_VAL,
  input  logic               CLR_ERR,
  output logic               MATCH_PULSE,
  output logic               WRAP_PULSE,
  output logic [WRAP_W-1:0]  WRAP_COUNT,
  output logic               SEQ_ERR,
  output logic               LOCKED,
  output logic [STATE_W-1:0] STATE
`ifdef SYNC3_MON_ERR_CAPTURE_EN
  ,
  output logic [CNT_W-1:0]   ERR_EXP,
  output logic [CNT_W-1:0]   ERR_GOT
`endif
);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             match_q, match_d;
  logic             wrap_q, wrap_d;
  logic             seq_err_q, seq_err_d;
  logic             locked_q, locked_d;

  logic             err_inc, err_clr;
  logic [ERR_W-1:0] err_cnt;
  logic [ERR_W-1:0] err_next;
  logic [CNT_W-1:0] exp_val;
  logic             legal;

`ifdef SYNC3_MON_ERR_CAPTURE_EN
  logic [CNT_W-1:0] err_exp_q, err_exp_d;
  logic [CNT_W-1:0] err_got_q, err_got_d;
`endif

  assign exp_val  = prev_q + CNT_W'(1);
  assign legal    = (CNT_IN == exp_val);
  // Value the mismatch counter takes if this sample is a mismatch; a clear in
  // the same cycle restarts the run at one.
  assign err_next = err_clr ? ERR_W'(1) : err_cnt + ERR_W'(1);

  // Next-state, reference value, pulses and error bookkeeping.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    match_d   = 1'b0;
    wrap_d    = 1'b0;
    seq_err_d = seq_err_q;
    locked_d  = 1'b0;
    err_inc   = 1'b0;
    err_clr   = 1'b0;
`ifdef SYNC3_MON_ERR_CAPTURE_EN
    err_exp_d = err_exp_q;
    err_got_d = err_got_q;
`endif
    if (!EN) begin
      state_d = ST_IDLE;
    end else begin
      if (CLR_ERR) begin
        seq_err_d = 1'b0;
        err_clr   = 1'b1;
`ifdef SYNC3_MON_ERR_CAPTURE_EN
        err_exp_d = '0;
        err_got_d = '0;
`endif
      end
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          prev_d  = CNT_IN;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          prev_d  = CNT_IN;
          match_d = (CNT_IN == MATCH_VAL);
          wrap_d  = (prev_q == '1) && (CNT_IN == '0);
          if (legal) begin
            locked_d = 1'b1;
            err_clr  = 1'b1;
          end else begin
            // A mismatch overrides a same-cycle CLR_ERR on the sticky flag.
            seq_err_d = 1'b1;
            err_inc   = 1'b1;
`ifdef SYNC3_MON_ERR_CAPTURE_EN
            if (!seq_err_q || CLR_ERR) begin
              err_exp_d = exp_val;
              err_got_d = CNT_IN;
            end
`endif
            if (err_next >= ERR_W'(ERR_LIMIT)) state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
          prev_d = CNT_IN;
          if (CLR_ERR) state_d = ST_ACQUIRE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      match_q   <= 1'b0;
      wrap_q    <= 1'b0;
      seq_err_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      match_q   <= match_d;
      wrap_q    <= wrap_d;
      seq_err_q <= seq_err_d;
      locked_q  <= locked_d;
    end
  end

`ifdef SYNC3_MON_ERR_CAPTURE_EN
  // First-mismatch capture registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_exp_q <= '0;
      err_got_q <= '0;
    end else begin
      err_exp_q <= err_exp_d;
      err_got_q <= err_got_d;
    end
  end

  assign ERR_EXP = err_exp_q;
  assign ERR_GOT = err_got_q;
`endif

  sync3_mon_sat_cnt #(.W(WRAP_W)) u_wrap_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (1'b0),
    .inc (wrap_d),
    .cnt (WRAP_COUNT)
  );

  sync3_mon_sat_cnt #(.W(ERR_W)) u_err_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (err_clr),
    .inc (err_inc),
    .cnt (err_cnt)
  );

  assign MATCH_PULSE = match_q;
  assign WRAP_PULSE  = wrap_q;
  assign SEQ_ERR     = seq_err_q;
  assign LOCKED      = locked_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_sync3_cnt_monitor.sv
// Directed bench for sync3_cnt_monitor. A second instance with a 2-bit wrap
// counter shares the stimulus to exercise saturation.
module tb_sync3_cnt_monitor;

  logic       CLK = 1'b0;
  logic       RST, EN, CLR_ERR;
  logic [2:0] CNT_IN, MATCH_VAL;

  logic       match_a, wrap_a, seq_err_a, locked_a;
  logic [7:0] wrap_cnt_a;
  logic [1:0] state_a;
  logic       match_b, wrap_b, seq_err_b, locked_b;
  logic [1:0] wrap_cnt_b;
  logic [1:0] state_b;
`ifdef SYNC3_MON_ERR_CAPTURE_EN
  logic [2:0] err_exp_a, err_got_a, err_exp_b, err_got_b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  sync3_cnt_monitor dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CNT_IN(CNT_IN), .MATCH_VAL(MATCH_VAL),
    .CLR_ERR(CLR_ERR), .MATCH_PULSE(match_a), .WRAP_PULSE(wrap_a),
    .WRAP_COUNT(wrap_cnt_a), .SEQ_ERR(seq_err_a), .LOCKED(locked_a),
    .STATE(state_a)
`ifdef SYNC3_MON_ERR_CAPTURE_EN
    , .ERR_EXP(err_exp_a), .ERR_GOT(err_got_a)
`endif
  );

  sync3_cnt_monitor #(.WRAP_W(2)) dut_w2 (
    .CLK(CLK), .RST(RST), .EN(EN), .CNT_IN(CNT_IN), .MATCH_VAL(MATCH_VAL),
    .CLR_ERR(CLR_ERR), .MATCH_PULSE(match_b), .WRAP_PULSE(wrap_b),
    .WRAP_COUNT(wrap_cnt_b), .SEQ_ERR(seq_err_b), .LOCKED(locked_b),
    .STATE(state_b)
`ifdef SYNC3_MON_ERR_CAPTURE_EN
    , .ERR_EXP(err_exp_b), .ERR_GOT(err_got_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Present one counter value, let the DUT sample it, then settle past the edge.
  task automatic cyc(input logic [2:0] v);
    @(negedge CLK);
    CNT_IN = v;
    @(posedge CLK);
    #1;
  endtask

  int match_seen;
  int match_adjacent;
  logic match_prev;

  initial begin
    RST = 1'b1; EN = 1'b0; CLR_ERR = 1'b0; CNT_IN = 3'd0; MATCH_VAL = 3'd5;
    cyc(3'd0);
    cyc(3'd0);
    chk("rst_state", state_a, 0);
    chk("rst_locked", locked_a, 0);
    chk("rst_seq_err", seq_err_a, 0);
    chk("rst_wrap_cnt", wrap_cnt_a, 0);
    chk("rst_pulses", {match_a, wrap_a}, 0);
`ifdef SYNC3_MON_ERR_CAPTURE_EN
    chk("rst_err_exp", err_exp_a, 0);
`endif

    // Bring-up and first full count cycle ending in a wrap.
    RST = 1'b0; EN = 1'b1;
    cyc(3'd7);
    chk("idle_to_acq", state_a, 1);
    cyc(3'd0);
    chk("acq_to_track", state_a, 2);
    chk("acq_no_lock", locked_a, 0);
    for (int v = 1; v <= 7; v++) begin
      cyc(3'(v));
      chk("up_locked", locked_a, 1);
      chk("up_no_wrap", wrap_a, 0);
      chk("up_match", match_a, (v == 5) ? 1 : 0);
    end
    cyc(3'd0);
    chk("wrap_pulse", wrap_a, 1);
    chk("wrap_cnt_1", wrap_cnt_a, 1);
    chk("wrap_locked", locked_a, 1);
    cyc(3'd1);
    chk("wrap_pulse_end", wrap_a, 0);

    // Sixteen legal samples 2..7,0..7,0,1: value 5 appears twice.
    match_seen = 0; match_adjacent = 0; match_prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc(3'((i + 2) % 8));
      if (match_a) match_seen++;
      if (match_a && match_prev) match_adjacent++;
      match_prev = match_a;
    end
    chk("match_count", match_seen, 2);
    chk("match_width", match_adjacent, 0);
    chk("wrap_cnt_3", wrap_cnt_a, 3);
    chk("w2_cnt_3", wrap_cnt_b, 3);

    // Single skip 3->6, then resync.
    cyc(3'd2);
    cyc(3'd3);
    cyc(3'd6);
    chk("skip_seq_err", seq_err_a, 1);
    chk("skip_unlocked", locked_a, 0);
    chk("skip_state", state_a, 2);
    cyc(3'd7);
    chk("resync_locked", locked_a, 1);
    chk("resync_state", state_a, 2);
    chk("sticky_err", seq_err_a, 1);
    CLR_ERR = 1'b1;
    cyc(3'd0);
    CLR_ERR = 1'b0;
    chk("clr_track_err", seq_err_a, 0);
    chk("clr_track_state", state_a, 2);
    chk("wrap_cnt_4", wrap_cnt_a, 4);
    chk("w2_sat_4", wrap_cnt_b, 3);

    // Stuck counter: fourth sample of 2 is the third mismatch.
    cyc(3'd1);
    cyc(3'd2);
    chk("stuck_legal", locked_a, 1);
    cyc(3'd2);
    chk("stuck_m1", state_a, 2);
    cyc(3'd2);
    chk("stuck_m2", state_a, 2);
    cyc(3'd2);
    chk("stuck_fault", state_a, 3);
    chk("fault_seq_err", seq_err_a, 1);
    chk("fault_unlocked", locked_a, 0);
    MATCH_VAL = 3'd2;
    cyc(3'd2);
    chk("fault_hold", state_a, 3);
    chk("fault_no_match", match_a, 0);
    MATCH_VAL = 3'd5;
    CLR_ERR = 1'b1;
    cyc(3'd3);
    CLR_ERR = 1'b0;
    chk("fault_clr_state", state_a, 1);
    chk("fault_clr_err", seq_err_a, 0);
    cyc(3'd4);
    chk("reacq_track", state_a, 2);
    cyc(3'd5);
    chk("reacq_locked", locked_a, 1);
    chk("reacq_match", match_a, 1);

    // Clear and mismatch together: the mismatch sets the flag.
    CLR_ERR = 1'b1;
    cyc(3'd0);
    CLR_ERR = 1'b0;
    chk("clr_vs_mis", seq_err_a, 1);
    chk("clr_vs_mis_st", state_a, 2);
    cyc(3'd1);

    // Enable drop mid-TRACK keeps status.
    EN = 1'b0;
    cyc(3'd2);
    chk("en_off_state", state_a, 0);
    chk("en_off_err", seq_err_a, 1);
    chk("en_off_wrap", wrap_cnt_a, 4);
    chk("en_off_lock", locked_a, 0);

    // Fifth wrap: default width counts on, 2-bit width stays saturated.
    EN = 1'b1;
    cyc(3'd6);
    cyc(3'd7);
    cyc(3'd0);
    chk("wrap5_pulse", wrap_a, 1);
    chk("wrap_cnt_5", wrap_cnt_a, 5);
    chk("w2_sat_5", wrap_cnt_b, 3);

    // Reset mid-TRACK.
    RST = 1'b1;
    MATCH_VAL = 3'd1;
    cyc(3'd1);
    chk("rst_mid_state", state_a, 0);
    chk("rst_mid_wrap", wrap_cnt_a, 0);
    chk("rst_mid_err", seq_err_a, 0);
    chk("rst_mid_outs", {match_a, wrap_a, locked_a}, 0);
    chk("rst_mid_w2", wrap_cnt_b, 0);
    MATCH_VAL = 3'd5;

    // First-mismatch capture: 1,2,4,0 -> exp 3 got 4, second miss ignored.
    RST = 1'b0;
    cyc(3'd0);
    cyc(3'd1);
    cyc(3'd2);
    cyc(3'd4);
    chk("cap_seq_err", seq_err_a, 1);
`ifdef SYNC3_MON_ERR_CAPTURE_EN
    chk("cap_exp", err_exp_a, 3);
    chk("cap_got", err_got_a, 4);
`endif
    cyc(3'd0);
    chk("cap2_state", state_a, 2);
`ifdef SYNC3_MON_ERR_CAPTURE_EN
    chk("cap2_exp", err_exp_a, 3);
    chk("cap2_got", err_got_a, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
